// File: rtl/dh_pkg.sv
// dh_pkg: shared state encoding and default widths for the Diffie-Hellman key-check blocks.
package dh_pkg;
  typedef enum logic [2:0] {IDLE, EXP, SEND, WAIT_C2, DONE} state_t;
  localparam int W_D = 32;
  localparam int KW_D = 4;
  localparam logic [W_D-1:0] ONE = 1;
endpackage

// File: rtl/mod_mul.sv
// mod_mul: combinational (a*b) mod p over a full 2W-bit product.
module mod_mul import dh_pkg::*; #(
  parameter int W = W_D
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [W-1:0] i_p,
  output logic [W-1:0] o_r
);
  logic [2*W-1:0] w_prod;
  assign w_prod = {{W{1'b0}}, i_a} * {{W{1'b0}}, i_b};
  assign o_r = W'(w_prod % {{W{1'b0}}, i_p});
endmodule

// File: rtl/decryption_r2.sv
// decryption_r2: initiator key check; k = r1^y mod p, sends c1 = k^r2, decrypts reply c2.
// Build option TIMEOUT_EN bounds the WAIT_C2 state to TMO_CYC clocks.
module decryption_r2 import dh_pkg::*; #(
  parameter int W = W_D,
  parameter int KW = KW_D
`ifdef TIMEOUT_EN
  , parameter int TMO_CYC = 1024
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] r1,
  input  logic [KW-1:0] r2,
  input  logic [W-1:0]  y,
  input  logic [W-1:0]  p,
  input  logic          c2_valid,
  input  logic [KW-1:0] c2,
  output logic          busy,
  output logic          c1_valid,
  output logic [KW-1:0] c1,
  output logic [KW-1:0] key,
  output logic          done,
  output logic          match,
  output logic          error
);
  localparam int CW = $clog2(W);
  state_t r_state;
  logic [W-1:0] r_acc, r_base, r_y, r_p;
  logic [KW-1:0] r_r1, r_r2;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] w_acc_mul, w_sq;
  logic w_lt2;
`ifdef TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] r_tmo;
`endif
  assign w_lt2 = p < W'(2);
  assign busy = r_state != IDLE;
  mod_mul #(.W(W)) u_acc (.i_a(r_acc), .i_b(r_base), .i_p(r_p), .o_r(w_acc_mul));
  mod_mul #(.W(W)) u_sq (.i_a(r_base), .i_b(r_base), .i_p(r_p), .o_r(w_sq));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_acc <= '0;
      r_base <= '0;
      r_y <= '0;
      r_p <= '0;
      r_r1 <= '0;
      r_r2 <= '0;
      r_cnt <= '0;
      c1_valid <= 1'b0;
      c1 <= '0;
      key <= '0;
      done <= 1'b0;
      match <= 1'b0;
      error <= 1'b0;
`ifdef TIMEOUT_EN
      r_tmo <= '0;
`endif
    end else begin
      c1_valid <= 1'b0;
      done <= 1'b0;
      case (r_state)
        IDLE: if (start) begin
          r_r1 <= r1;
          r_r2 <= r2;
          r_y <= y;
          r_p <= p;
          r_acc <= W'(ONE);
          // a modulus below 2 never reaches the datapath, so skip the divide
          r_base <= w_lt2 ? '0 : {{(W-KW){1'b0}}, r1} % p;
          r_cnt <= '0;
          match <= 1'b0;
          error <= w_lt2;
          done <= w_lt2;
          r_state <= w_lt2 ? DONE : EXP;
        end
        EXP: begin
          if (r_y[0]) r_acc <= w_acc_mul;
          r_base <= w_sq;
          r_y <= r_y >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) r_state <= SEND;
        end
        SEND: begin
          c1_valid <= 1'b1;
          c1 <= r_acc[KW-1:0] ^ r_r2;
          key <= r_acc[KW-1:0];
          r_state <= WAIT_C2;
`ifdef TIMEOUT_EN
          r_tmo <= '0;
`endif
        end
        WAIT_C2: if (c2_valid) begin
          match <= (c2 ^ key) == r_r1;
          done <= 1'b1;
          r_state <= DONE;
        end
`ifdef TIMEOUT_EN
        else if (r_tmo == TW'(TMO_CYC-1)) begin
          error <= 1'b1;
          done <= 1'b1;
          r_state <= DONE;
        end else r_tmo <= r_tmo + 1'b1;
`endif
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_decryption_r2.sv
// tb_decryption_r2: table-driven scoreboard bench for decryption_r2.
module tb_decryption_r2;
  localparam int W = 32;
  localparam int KW = 4;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, c2_valid = 1'b0;
  logic [KW-1:0] r1 = '0, r2 = '0, c2 = '0;
  logic [W-1:0] y = '0, p = '0;
  logic busy, c1_valid, done, match, error;
  logic [KW-1:0] c1, key;
  always #5 clk = ~clk;

  decryption_r2 dut (
    .clk(clk), .rst(rst), .start(start), .r1(r1), .r2(r2), .y(y), .p(p),
    .c2_valid(c2_valid), .c2(c2), .busy(busy), .c1_valid(c1_valid), .c1(c1),
    .key(key), .done(done), .match(match), .error(error)
  );

  typedef struct {
    logic [W-1:0] p, y;
    logic [KW-1:0] r1, r2, c2, key, c1;
    logic match, err;
  } vec_t;
  typedef struct {
    logic [KW-1:0] key, c1;
    logic match, err;
  } exp_t;

  exp_t sb[$];
  vec_t vt[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // left-to-right exponentiation, independent of the LSB-first datapath
  function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e, input logic [W-1:0] m);
    longint unsigned r, bb;
    if (m < 2) return '0;
    r = 1;
    bb = b % m;
    for (int i = W-1; i >= 0; i--) begin
      r = (r * r) % m;
      if (e[i]) r = (r * bb) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic vec_t mk(input logic [W-1:0] pp, input logic [KW-1:0] a, input logic [KW-1:0] b,
                              input logic [W-1:0] yy, input logic [KW-1:0] cc);
    vec_t v;
    logic [W-1:0] k;
    k = modexp({{(W-KW){1'b0}}, a}, yy, pp);
    v.p = pp; v.y = yy; v.r1 = a; v.r2 = b; v.c2 = cc;
    v.key = k[KW-1:0];
    v.c1 = v.key ^ b;
    v.err = pp < 2;
    v.match = !v.err && ((cc ^ v.key) == a);
    return v;
  endfunction

  always @(negedge clk) if (!rst) begin
    if (c1_valid) begin
      if (sb.size() == 0) check("c1_unexpected", 1, 0);
      else begin
        check("c1", c1, sb[0].c1);
        check("key", key, sb[0].key);
        check("c1_on_error", sb[0].err, 0);
      end
    end
    if (done) begin
      if (sb.size() == 0) check("done_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("match", match, e.match);
        check("error", error, e.err);
      end
    end
  end

  task automatic drive_start(input vec_t v);
    sb.push_back('{v.key, v.c1, v.match, v.err});
    @(negedge clk);
    p = v.p; y = v.y; r1 = v.r1; r2 = v.r2; start = 1'b1;
  endtask

  task automatic wait_c1(output int n);
    n = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!c1_valid && n < 200);
  endtask

  task automatic reply(input logic [KW-1:0] v);
    c2 = v; c2_valid = 1'b1;
    @(negedge clk);
    c2_valid = 1'b0;
    check("done_after_c2", done, 1);
  endtask

  task automatic run(input vec_t v);
    int n;
    drive_start(v);
    if (v.err) begin
      n = 0;
      do begin
        @(negedge clk);
        start = 1'b0;
        n++;
      end while (!done && n < 100);
      check("err_done_lat", n, 1);
    end else begin
      wait_c1(n);
      check("c1_lat", n - 1, W + 1);
      reply(v.c2);
    end
    repeat (2) @(negedge clk);
    check("match_hold", match, v.match);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    vt.push_back('{32'd23, 32'd6, 4'd5, 4'd3, 4'hD, 4'd8, 4'hB, 1'b1, 1'b0});
    vt.push_back('{32'd23, 32'd6, 4'd5, 4'd3, 4'h0, 4'd8, 4'hB, 1'b0, 1'b0});
    vt.push_back('{32'd23, 32'd0, 4'd5, 4'd3, 4'h4, 4'd1, 4'h2, 1'b1, 1'b0});
    vt.push_back('{32'd1, 32'd6, 4'd5, 4'd3, 4'h0, 4'd0, 4'h0, 1'b0, 1'b1});
    vt.push_back('{32'd0, 32'd9, 4'd7, 4'd1, 4'h0, 4'd0, 4'h0, 1'b0, 1'b1});
    vt.push_back('{32'd7, 32'd3, 4'd12, 4'hA, 4'hA, 4'd6, 4'hC, 1'b1, 1'b0});
    vt.push_back('{32'd2, 32'd5, 4'd3, 4'hF, 4'h0, 4'd1, 4'hE, 1'b0, 1'b0});
    vt.push_back(mk(32'd1000003, 4'd7, 4'd5, 32'hDEADBEEF, 4'd0));
    vt.push_back(mk(32'hFFFFFFFB, 4'd15, 4'd9, 32'hFFFFFFFF, 4'd6));
    vt.push_back(mk(32'h8000000B, 4'd11, 4'd0, 32'h12345678, 4'd3));
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_c1_valid", c1_valid, 0);
    check("rst_done", done, 0);
    check("rst_match", match, 0);
    check("rst_error", error, 0);
    check("rst_key", key, 0);
    check("rst_c1", c1, 0);
    rst = 1'b0;
    foreach (vt[i]) run(vt[i]);

    // start pulses mid-exponentiation must not disturb the running exchange
    drive_start(vt[0]);
    n = 0;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    p = 32'd1; y = '0; r1 = 4'd2; start = 1'b1;
    check("busy_exp", busy, 1);
    do begin
      @(negedge clk);
      start = 1'b0;
      n++;
    end while (!c1_valid && n < 200);
    check("ignored_start_lat", n - 1, W + 1);
    reply(vt[0].c2);
    repeat (2) @(negedge clk);

    // asynchronous abort 10 clocks into EXP, then a clean exchange
    drive_start(vt[0]);
    repeat (11) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_c1_valid", c1_valid, 0);
    check("abort_done", done, 0);
    check("abort_key", key, 0);
    check("abort_error", error, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    run(vt[2]);

    // no reply after SEND
`ifdef TIMEOUT_EN
    begin
      vec_t v;
      v = vt[0];
      v.match = 1'b0;
      v.err = 1'b1;
      drive_start(v);
      wait_c1(n);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 3000);
      check("timeout_lat", n, 1024);
      @(negedge clk);
    end
`else
    drive_start(vt[0]);
    wait_c1(n);
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!busy || done) bad++;
    end
    check("wait_forever", bad, 0);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
`endif
    run(vt[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
